// File: rtl/ofdm_framer_pkg.sv
// Shared types, defaults and the IFFT bin-to-carrier mapping for the subcarrier mapper.
package ofdm_framer_pkg;

  localparam int FFT_SIZE_DEF      = 1024;
  localparam int USED_CARRIERS_DEF = 800;
  localparam int SYNC_BEAT_BITS    = 32;
  localparam logic signed [15:0] AMPLITUDE_DEF = 16'sh2D41;

  typedef struct packed {
    logic signed [15:0] q;
    logic signed [15:0] i;
  } sample_t;

  typedef struct packed {
    logic        is_null;
    logic [15:0] idx;
  } bin_map_t;

  // Natural IFFT order: upper half of the carriers right after DC, lower half at the top bins.
  function automatic bin_map_t bin_to_carrier(input int k, input int fft_size, input int used);
    bin_map_t m;
    int       h;
    h         = used / 2;
    m.is_null = 1'b1;
    m.idx     = '0;
    if (k >= 1 && k <= h) begin
      m.is_null = 1'b0;
      m.idx     = 16'(h + k - 1);
    end else if (k >= fft_size - h && k < fft_size) begin
      m.is_null = 1'b0;
      m.idx     = 16'(k - (fft_size - h));
    end
    return m;
  endfunction

endpackage

// File: rtl/ofdm_symbol_pingpong.sv
// Two-bank symbol bit buffer: masked insert at the write offset, per-bank full/sync flags, read-bit mux.
module ofdm_symbol_pingpong
  import ofdm_framer_pkg::*;
#(
  parameter int USED_CARRIERS = USED_CARRIERS_DEF,
  parameter int BEAT_W        = 40,
  parameter int FILL_W        = $clog2(USED_CARRIERS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [FILL_W-1:0] wr_off,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic [BEAT_W-1:0] wr_mask,
  input  logic              wr_first,
  input  logic              wr_sync,
  input  logic              wr_done,
  input  logic              rd_release,
  input  logic              rd_bank,
  input  logic [15:0]       rd_idx,
  output logic [1:0]        full,
  output logic [1:0]        sync,
  output logic              rd_bit
);

  logic [USED_CARRIERS-1:0] bank [2];
  logic [USED_CARRIERS-1:0] ins_mask;
  logic [USED_CARRIERS-1:0] ins_data;

  // Bits shifted past the symbol end fall off, which truncates an overrunning beat.
  assign ins_mask = USED_CARRIERS'(wr_mask) << wr_off;
  assign ins_data = USED_CARRIERS'(wr_data) << wr_off;

  always_ff @(posedge clk) begin
    if (wr_en) bank[wr_bank] <= (bank[wr_bank] & ~ins_mask) | (ins_data & ins_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      sync <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_done && wr_bank == 1'(b)) full[b] <= 1'b1;
        else if (rd_release && rd_bank == 1'(b)) full[b] <= 1'b0;
        if (wr_en && wr_first && wr_bank == 1'(b)) sync[b] <= wr_sync;
      end
    end
  end

  assign rd_bit = |(bank[rd_bank] & (USED_CARRIERS'(1) << rd_idx));

endmodule

// File: rtl/ofdm_subcarrier_mapper.sv
// BPSK subcarrier mapper: buffers one symbol of carrier bits, then streams FFT_SIZE bins in IFFT order.
// state  | meaning
// IDLE   | no full bank to stream, output invalid
// STREAM | presenting bin k of bank rd_bank, advancing on each output handshake
module ofdm_subcarrier_mapper
  import ofdm_framer_pkg::*;
#(
  parameter int                 FFT_SIZE           = FFT_SIZE_DEF,
  parameter int                 USED_CARRIERS      = USED_CARRIERS_DEF,
  parameter int                 S_AXIS_TDATA_WIDTH = 40,
  parameter int                 M_AXIS_TDATA_WIDTH = 32,
  parameter logic signed [15:0] AMPLITUDE          = AMPLITUDE_DEF
) (
  input  logic                            s_axis_data_aclk,
  input  logic                            s_axis_data_areset,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]   s_axis_data_tdata,
  input  logic [S_AXIS_TDATA_WIDTH/8-1:0] s_axis_data_tstrb,
  input  logic                            s_axis_data_tvalid,
  output logic                            s_axis_data_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0]   m_axis_data_tdata,
  output logic                            m_axis_data_tvalid,
  input  logic                            m_axis_data_tready,
  output logic                            m_axis_data_tlast,
  output logic                            m_axis_data_tuser
);

  localparam int FILL_W = $clog2(USED_CARRIERS + 1);
  localparam int K_W    = $clog2(FFT_SIZE);
  localparam logic [FILL_W:0] USED_V   = (FILL_W + 1)'(USED_CARRIERS);
  localparam logic [FILL_W:0] LEN_SYNC = (FILL_W + 1)'(SYNC_BEAT_BITS);
  localparam logic [FILL_W:0] LEN_DATA = (FILL_W + 1)'(S_AXIS_TDATA_WIDTH);
  localparam logic [S_AXIS_TDATA_WIDTH-1:0] MASK_SYNC = S_AXIS_TDATA_WIDTH'({SYNC_BEAT_BITS{1'b1}});
  localparam logic [K_W-1:0] K_LAST   = K_W'(FFT_SIZE - 1);
  localparam logic [K_W-1:0] K_PENULT = K_W'(FFT_SIZE - 2);

  typedef enum logic {IDLE, STREAM} rd_state_t;

  rd_state_t         state;
  logic [K_W-1:0]    k;
  logic              wr_bank;
  logic              rd_bank;
  logic [FILL_W-1:0] fill;
  logic [FILL_W:0]   fill_sum;
  logic [1:0]        full;
  logic [1:0]        sync;
  logic              beat_sync;
  logic              wr_fire;
  logic              wr_done;
  logic              rd_release;
  logic              rd_bit;
  logic              start;
  logic              other_full;
  bin_map_t          map_nxt;
  sample_t           samp_nxt;
  logic              strb_unused;

  assign beat_sync          = s_axis_data_tstrb[0];
  assign strb_unused        = ^s_axis_data_tstrb[S_AXIS_TDATA_WIDTH/8-1:1];
  assign s_axis_data_tready = !full[wr_bank];
  assign wr_fire            = s_axis_data_tvalid && s_axis_data_tready;
  assign fill_sum           = {1'b0, fill} + (beat_sync ? LEN_SYNC : LEN_DATA);
  assign wr_done            = wr_fire && (fill_sum >= USED_V);

  always_ff @(posedge s_axis_data_aclk) begin
    if (s_axis_data_areset) begin
      wr_bank <= 1'b0;
      fill    <= '0;
    end else if (wr_fire) begin
      if (wr_done) begin
        wr_bank <= ~wr_bank;
        fill    <= '0;
      end else begin
        fill <= fill_sum[FILL_W-1:0];
      end
    end
  end

  ofdm_symbol_pingpong #(
    .USED_CARRIERS (USED_CARRIERS),
    .BEAT_W        (S_AXIS_TDATA_WIDTH),
    .FILL_W        (FILL_W)
  ) u_pingpong (
    .clk        (s_axis_data_aclk),
    .rst        (s_axis_data_areset),
    .wr_en      (wr_fire),
    .wr_bank    (wr_bank),
    .wr_off     (fill),
    .wr_data    (s_axis_data_tdata),
    .wr_mask    (beat_sync ? MASK_SYNC : '1),
    .wr_first   (fill == '0),
    .wr_sync    (beat_sync),
    .wr_done    (wr_done),
    .rd_release (rd_release),
    .rd_bank    (rd_bank),
    .rd_idx     (map_nxt.idx),
    .full       (full),
    .sync       (sync),
    .rd_bit     (rd_bit)
  );

  // Completing writes count as full this cycle so the reader starts without an extra bubble.
  assign start      = full[rd_bank] || (wr_done && (wr_bank == rd_bank));
  assign other_full = full[~rd_bank] || (wr_done && (wr_bank != rd_bank));
  assign rd_release = (state == STREAM) && m_axis_data_tready && (k == K_LAST);
  assign map_nxt    = bin_to_carrier(int'(k) + 1, FFT_SIZE, USED_CARRIERS);

  always_comb begin
    samp_nxt = '0;
    if (!map_nxt.is_null) samp_nxt.i = rd_bit ? AMPLITUDE : -AMPLITUDE;
  end

  always_ff @(posedge s_axis_data_aclk) begin
    if (s_axis_data_areset) begin
      state              <= IDLE;
      k                  <= '0;
      rd_bank            <= 1'b0;
      m_axis_data_tvalid <= 1'b0;
      m_axis_data_tdata  <= '0;
      m_axis_data_tlast  <= 1'b0;
      m_axis_data_tuser  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state              <= STREAM;
            k                  <= '0;
            m_axis_data_tvalid <= 1'b1;
            m_axis_data_tdata  <= '0;
            m_axis_data_tlast  <= 1'b0;
            m_axis_data_tuser  <= sync[rd_bank];
          end
        end
        STREAM: begin
          if (m_axis_data_tready) begin
            if (k == K_LAST) begin
              rd_bank           <= ~rd_bank;
              k                 <= '0;
              m_axis_data_tdata <= '0;
              m_axis_data_tlast <= 1'b0;
              if (other_full) begin
                m_axis_data_tuser <= sync[~rd_bank];
              end else begin
                state              <= IDLE;
                m_axis_data_tvalid <= 1'b0;
                m_axis_data_tuser  <= 1'b0;
              end
            end else begin
              k                 <= k + 1'b1;
              m_axis_data_tdata <= M_AXIS_TDATA_WIDTH'(samp_nxt);
              m_axis_data_tlast <= (k == K_PENULT);
              m_axis_data_tuser <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  overflow_chk: assert property (@(posedge s_axis_data_aclk) disable iff (s_axis_data_areset)
    wr_fire |-> (fill_sum <= USED_V))
    else $error("input beat overruns the symbol boundary");

endmodule

// File: tb/tb_ofdm_subcarrier_mapper.sv
// Scoreboard bench for ofdm_subcarrier_mapper: expected bins queued per driven symbol, popped on output.
module tb_ofdm_subcarrier_mapper;

  localparam int FFT  = 1024;
  localparam int USED = 800;
  localparam int H    = USED / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [39:0] s_tdata = '0;
  logic [4:0]  s_tstrb = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;

  int   rdy_mode = 0;
  logic rnd_bit  = 1'b0;

  typedef struct {
    int          k;
    logic [33:0] v;
  } exp_t;

  exp_t            sb[$];
  logic [USED-1:0] car_bits;
  int              n_cmp = 0;
  int              n_mis = 0;
  int              n_out = 0;
  logic            stalled = 1'b0;
  logic [34:0]     held;

  ofdm_subcarrier_mapper dut (
    .s_axis_data_aclk   (clk),
    .s_axis_data_areset (rst),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tstrb  (s_tstrb),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .m_axis_data_tlast  (m_tlast),
    .m_axis_data_tuser  (m_tuser)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  assign m_tready = (rdy_mode == 1) || ((rdy_mode == 2) && rnd_bit);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) chk("stall_hold", {m_tvalid, m_tuser, m_tlast, m_tdata}, held);
      if (m_tvalid && m_tready) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          chk($sformatf("bin%0d", e.k), {m_tuser, m_tlast, m_tdata}, e.v);
        end
      end
      stalled = m_tvalid && !m_tready;
      held    = {m_tvalid, m_tuser, m_tlast, m_tdata};
    end
  end

  task automatic push_symbol(input logic sync_f);
    for (int k = 0; k < FFT; k++) begin
      int          c;
      logic [31:0] d;
      exp_t        e;
      c = -1;
      if (k >= 1 && k <= H) c = H + k - 1;
      else if (k >= FFT - H) c = k - (FFT - H);
      if (c < 0) d = 32'h0;
      else d = car_bits[c] ? 32'h0000_2D41 : 32'h0000_D2BF;
      e.k = k;
      e.v = {sync_f && (k == 0), (k == FFT - 1), d};
      sb.push_back(e);
    end
  endtask

  task automatic drive_beat(input logic [39:0] d, input logic s);
    int   n;
    logic ok;
    n = 0;
    ok = 1'b0;
    s_tdata  = d;
    s_tstrb  = {4'b0000, s};
    s_tvalid = 1'b1;
    while (!ok && n < 8000) begin
      @(negedge clk);
      ok = s_tready;
      n++;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("wr_handshake_timeout", 64'(ok), 64'd1);
  endtask

  // mode 0: all-ones sync beats, 1: carrier 0 of each 40-bit beat, 2: random data beats,
  // 3: random mixed widths starting with a data beat, 4: random mixed widths starting with sync beats
  task automatic send_symbol(input int mode, input bit do_push, input int max_beats);
    logic [39:0] bd[$];
    logic        bs[$];
    int          off;
    int          len;
    int          idx;
    logic [63:0] r;
    logic [39:0] d;
    logic        s;
    off = 0;
    idx = 0;
    while (off < USED) begin
      r = {$urandom, $urandom};
      case (mode)
        0:       begin s = 1'b1; d = 40'h00_FFFF_FFFF; end
        1:       begin s = 1'b0; d = 40'h1; end
        2:       begin s = 1'b0; d = r[39:0]; end
        3:       begin s = (idx % 4 == 1) && (idx < 20); d = r[39:0]; end
        default: begin s = (idx < 5); d = r[39:0]; end
      endcase
      len = s ? 32 : 40;
      for (int j = 0; j < len; j++) car_bits[off + j] = d[j];
      off += len;
      idx++;
      bd.push_back(d);
      bs.push_back(s);
    end
    if (do_push) push_symbol(bs[0]);
    for (int i = 0; i < bd.size(); i++) begin
      if (max_beats == 0 || i < max_beats) drive_beat(bd[i], bs[i]);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n;
    int n0;
    int run;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_tuser", 64'(m_tuser), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd1);

    rdy_mode = 1;
    send_symbol(0, 1'b1, 0);
    chk("latency_tvalid", 64'(m_tvalid), 64'd1);
    wait_drain();
    send_symbol(1, 1'b1, 0);
    wait_drain();
    send_symbol(3, 1'b1, 0);
    wait_drain();
    send_symbol(4, 1'b1, 0);
    wait_drain();

    rdy_mode = 0;
    send_symbol(2, 1'b1, 0);
    send_symbol(2, 1'b1, 0);
    chk("bp_s_tready_low", 64'(s_tready), 64'd0);
    fork
      send_symbol(0, 1'b1, 0);
      begin
        repeat (2950) @(posedge clk);
        #1;
        chk("bp_hold_s_tready", 64'(s_tready), 64'd0);
        chk("bp_hold_tvalid", 64'(m_tvalid), 64'd1);
        rdy_mode = 1;
        run = 0;
        while (run < 4000) begin
          @(negedge clk);
          if (!m_tvalid) break;
          run++;
        end
        chk("bp_gapless_run", 64'(run), 64'd3072);
      end
    join
    wait_drain();

    rdy_mode = 2;
    send_symbol(2, 1'b1, 0);
    send_symbol(4, 1'b1, 0);
    send_symbol(1, 1'b1, 0);
    wait_drain();
    rdy_mode = 1;

    n0 = n_out;
    send_symbol(2, 1'b1, 0);
    send_symbol(1, 1'b0, 10);
    n = 0;
    while ((n_out - n0) < 500 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_bin500", 64'((n_out - n0) >= 500), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'd1);
    chk("midrst_fill", 64'(dut.fill), 64'd0);
    send_symbol(0, 1'b1, 0);
    chk("midrst_latency_tvalid", 64'(m_tvalid), 64'd1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_mis);
    $fatal(1, "watchdog");
  end

endmodule
